// File: rtl/window_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_line_buffer
// Description : Streaming FxF sliding-window generator feeding the conv unit.
//               Pixels arrive one per handshake in raster order. F-1 line
//               buffers (depth W) hold the previous lines; an FxF register
//               array shifts left on every accept and takes a new right-hand
//               column built from the line buffers plus the incoming pixel.
//               Each complete window is presented as one flat bus.
//
//               Optional feature macro:
//                 WINDOW_STRIDE2_EN - emit only windows whose top-left
//                                     corner sits on an even row and column
//                                     offset (stride 2). Buffering and
//                                     accept behaviour are unchanged.
//
// Ports       : clk          - rising-edge clock
//               reset        - synchronous, active-high
//               pix_in       - pixel, channel d at [d*DATA_WIDTH+:DATA_WIDTH]
//               pix_valid    - pix_in valid
//               pix_ready    - block can accept pix_in this cycle
//               window       - flat window, element (d*F+r)*F+c
//               window_valid - window holds a complete window
//               window_ready - consumer takes window this cycle
//               frame_done   - 1-cycle pulse after the last pixel of a frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module window_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int F          = 5,
    parameter int W          = 32,
    parameter int H          = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [0:D*DATA_WIDTH-1]         pix_in,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    output logic [0:D*F*F*DATA_WIDTH-1]     window,
    output logic                            window_valid,
    input  logic                            window_ready,
    output logic                            frame_done
);

    localparam int c_PIX_W = D * DATA_WIDTH;
    localparam int c_CW    = (W > 1) ? $clog2(W) : 1;
    localparam int c_RW    = (H > 1) ? $clog2(H) : 1;

    localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'(H - 1);
    localparam logic [c_CW-1:0] c_COL_FIRST = c_CW'(F - 1);
    localparam logic [c_RW-1:0] c_ROW_FIRST = c_RW'(F - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_CW-1:0]       col_q, col_d;
    logic [c_RW-1:0]       row_q, row_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;

    // lb_q[0] holds the oldest line (row-(F-1)), lb_q[F-2] the previous line.
    logic [0:c_PIX_W-1]    lb_q  [0:F-2][0:W-1];
    logic [DATA_WIDTH-1:0] win_q [0:D-1][0:F-1][0:F-1];

    logic                  w_accept;
    logic                  w_emit;
    logic                  w_phase_ok;
    logic [0:c_PIX_W-1]    w_col_new [0:F-1];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign pix_ready    = !valid_q || window_ready;
    assign w_accept     = pix_valid && pix_ready;
    assign window_valid = valid_q;
    assign frame_done   = done_q;

`ifdef WINDOW_STRIDE2_EN
    // (row-(F-1)) is even exactly when row and F-1 share bit 0.
    assign w_phase_ok = (row_q[0] == c_ROW_FIRST[0]) && (col_q[0] == c_COL_FIRST[0]);
`else
    assign w_phase_ok = 1'b1;
`endif

    // A window is complete once F-1 full lines are buffered and the current
    // line has supplied at least F columns; the col test also stops windows
    // from straddling a line wrap.
    assign w_emit = w_accept && (row_q >= c_ROW_FIRST) && (col_q >= c_COL_FIRST) && w_phase_ok;

    // ------------------------------------------------------------------
    // New right-hand column: buffered lines oldest..newest, then pix_in.
    // The line buffer location at col_q still holds the previous line's
    // pixel when read here; it is overwritten on the same edge.
    // ------------------------------------------------------------------
    assign w_col_new[F-1] = pix_in;

    generate
        for (genvar r = 0; r < F - 1; r++) begin : g_col_new
            assign w_col_new[r] = lb_q[r][col_q];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (w_accept) begin
            if (col_q == c_COL_LAST) begin
                col_d = '0;
                row_d = (row_q == c_ROW_LAST) ? '0 : row_q + c_RW'(1);
            end else begin
                col_d = col_q + c_CW'(1);
            end
            done_d = (row_q == c_ROW_LAST) && (col_q == c_COL_LAST);
        end

        // A freshly loaded window wins over consumption of the old one.
        if (w_emit) begin
            valid_d = 1'b1;
        end else if (window_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: each accept pushes a pixel down the chain at the
    // current column address. Contents need no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            lb_q[F-2][col_q] <= pix_in;
            for (int k = 0; k < F - 2; k++) begin
                lb_q[k][col_q] <= lb_q[k+1][col_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Window registers: shift left one column per accept. No accept can
    // happen while a window is held (pix_ready low), so the window is
    // stable for the consumer without extra gating.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < D; d++) begin
                for (int r = 0; r < F; r++) begin
                    for (int c = 0; c < F; c++) begin
                        win_q[d][r][c] <= '0;
                    end
                end
            end
        end else if (w_accept) begin
            for (int d = 0; d < D; d++) begin
                for (int r = 0; r < F; r++) begin
                    for (int c = 0; c < F - 1; c++) begin
                        win_q[d][r][c] <= win_q[d][r][c+1];
                    end
                    win_q[d][r][F-1] <= w_col_new[r][d*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Flatten: element (d*F+r)*F+c, index 0 is the conv unit's first word.
    // ------------------------------------------------------------------
    generate
        for (genvar d = 0; d < D; d++) begin : g_ch
            for (genvar r = 0; r < F; r++) begin : g_row
                for (genvar c = 0; c < F; c++) begin : g_col
                    assign window[((d*F+r)*F+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[d][r][c];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_window_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_line_buffer
// Description : Directed self-checking bench for window_line_buffer with
//               W=8, H=8, F=3, D=1 and pixel value row*8+col. Expected
//               windows come from the corner enumeration of each frame;
//               stride follows the WINDOW_STRIDE2_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_line_buffer;

    localparam int DW = 16;
    localparam int D  = 1;
    localparam int F  = 3;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int WB = D * F * F * DW;
`ifdef WINDOW_STRIDE2_EN
    localparam int S  = 2;
`else
    localparam int S  = 1;
`endif
    localparam int NC   = (W - F + 1 + S - 1) / S;
    localparam int NR   = (H - F + 1 + S - 1) / S;
    localparam int NWIN = NC * NR;

    logic              clk = 1'b0;
    logic              reset;
    logic [0:D*DW-1]   pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [0:WB-1]     window;
    logic              window_valid;
    logic              window_ready;
    logic              frame_done;

    int n_vec;
    int n_err;
    int n_acc;
    int n_win;
    int n_done;
    int done_acc;
    int first_valid_acc;
    int tr;
    int tc;

    always #5 clk = ~clk;

    window_line_buffer #(
        .DATA_WIDTH (DW),
        .D          (D),
        .F          (F),
        .W          (W),
        .H          (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .window       (window),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .frame_done   (frame_done)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window whose top-left pixel is (r,c).
    function automatic logic [255:0] exp_win(input int r, input int c);
        logic [0:WB-1] v;
        logic [DW-1:0] e;
        v = '0;
        for (int rr = 0; rr < F; rr++) begin
            for (int cc = 0; cc < F; cc++) begin
                e = DW'((r + rr) * W + c + cc);
                v[(rr*F+cc)*DW +: DW] = e;
            end
        end
        return 256'(v);
    endfunction

    // idx-th window of a frame, raster order of top-left corners.
    function automatic logic [255:0] exp_idx_win(input int idx);
        int k;
        k = idx % NWIN;
        return exp_win((k / NC) * S, (k % NC) * S);
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later.
    task automatic cycle(input logic v, input logic rdy);
        @(negedge clk);
        pix_valid    = v;
        window_ready = rdy;
        pix_in       = DW'(tr * W + tc);
        #1;
        if (frame_done) begin
            n_done++;
            done_acc = n_acc;
        end
        if (window_valid && first_valid_acc < 0)
            first_valid_acc = n_acc;
        check("pix_ready", {255'b0, pix_ready}, {255'b0, (!window_valid || rdy)});
        if (window_valid && rdy) begin
            check($sformatf("window%0d", n_win), window, exp_idx_win(n_win));
            n_win++;
        end
        if (v && pix_ready) begin
            n_acc++;
            if (tc == W - 1) begin
                tc = 0;
                tr = (tr == H - 1) ? 0 : tr + 1;
            end else begin
                tc++;
            end
        end
    endtask

    // One reset cycle with pix_valid high to show reset wins; then check
    // the post-reset state.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        pix_valid    = 1'b1;
        window_ready = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        pix_valid = 1'b0;
        tr = 0; tc = 0;
        n_acc = 0; n_win = 0; n_done = 0;
        done_acc = -1; first_valid_acc = -1;
        #1;
        check("rst_window_valid", {255'b0, window_valid}, 256'd0);
        check("rst_frame_done",   {255'b0, frame_done},   256'd0);
        check("rst_window",       256'(window),           256'd0);
        check("rst_pix_ready",    {255'b0, pix_ready},    256'd1);
    endtask

    task automatic stream(input int n, input logic rdy);
        int target;
        int budget;
        target = n_acc + n;
        budget = n * 8 + 20;
        while (n_acc < target && budget > 0) begin
            cycle(1'b1, rdy);
            budget--;
        end
        if (n_acc < target)
            check("stream_timeout", 256'(n_acc), 256'(target));
    endtask

    task automatic flush();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; pix_valid = 1'b0; window_ready = 1'b0; pix_in = '0;
        tr = 0; tc = 0;
        repeat (2) @(posedge clk);

        // Full frame, consumer always ready.
        do_reset();
        stream(W * H, 1'b1);
        flush();
        check("t1_first_valid_after_accept", 256'(first_valid_acc), 256'd19);
        check("t2_windows_per_frame",        256'(n_win),           256'(NWIN));
        check("t2_frame_done_count",         256'(n_done),          256'd1);
        check("t2_frame_done_after_accept",  256'(done_acc),        256'(W * H));

        // Consumer stalls 5 cycles on the first window.
        do_reset();
        stream(19, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0);
            check("t3_hold_pix_ready", {255'b0, pix_ready}, 256'd0);
            check("t3_hold_window",    256'(window),        exp_win(0, 0));
        end
        check("t3_no_accept_in_hold", 256'(n_acc), 256'd19);
        stream(10, 1'b1);
        check("t3_windows_after_release", 256'(n_win >= 2), 256'd1);

        // Reset mid-frame, then a clean frame.
        do_reset();
        stream(30, 1'b1);
        do_reset();
        stream(W * H, 1'b1);
        flush();
        check("t4_first_valid_after_accept", 256'(first_valid_acc), 256'd19);
        check("t4_windows_per_frame",        256'(n_win),           256'(NWIN));

        // Two back-to-back frames.
        do_reset();
        stream(2 * W * H, 1'b1);
        flush();
        check("t5_windows_two_frames", 256'(n_win),    256'(2 * NWIN));
        check("t5_frame_done_count",   256'(n_done),   256'd2);
        check("t5_last_frame_done_at", 256'(done_acc), 256'(2 * W * H));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
